// File: rtl/reg_port_ctrl_pkg.sv
// Shared widths and FSM state encodings for the register-stack requester port.
package reg_port_ctrl_pkg;

  localparam int DEF_WORD_WIDTH     = 16;
  localparam int DEF_NIB_WIDTH      = 4;
  localparam int DEF_REG_STACK_SIZE = 16;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_CAP  = 2'd2,
    RD_HOLD = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_SETUP  = 2'd1,
    WB_STROBE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/reg_port_ctrl_scoreboard.sv
// Per-register busy bits: set on issue of a writing op, cleared on its writeback strobe.
module reg_port_ctrl_scoreboard
  import reg_port_ctrl_pkg::*;
#(
  parameter int NIB_WIDTH      = DEF_NIB_WIDTH,
  parameter int REG_STACK_SIZE = DEF_REG_STACK_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [NIB_WIDTH-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [NIB_WIDTH-1:0] clr_idx,
  input  logic [NIB_WIDTH-1:0] rd_idx1,
  input  logic [NIB_WIDTH-1:0] rd_idx2,
  output logic                 busy1,
  output logic                 busy2
);

  localparam int NUM_IDX = 2 ** NIB_WIDTH;

  logic [NUM_IDX-1:0] busy;
  logic [NUM_IDX-1:0] valid_mask;
  logic [NUM_IDX-1:0] set_vec;
  logic [NUM_IDX-1:0] clr_vec;

  // Indices beyond the stack never get a busy bit, so lookups on them read 0.
  for (genvar i = 0; i < NUM_IDX; i++) begin : g_mask
    assign valid_mask[i] = (i < REG_STACK_SIZE);
  end

  assign set_vec = set_en ? ((NUM_IDX'(1) << set_idx) & valid_mask) : '0;
  assign clr_vec = clr_en ? (NUM_IDX'(1) << clr_idx) : '0;

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_vec) | set_vec;
  end

  assign busy1 = busy[rd_idx1];
  assign busy2 = busy[rd_idx2];

endmodule

// File: rtl/reg_port_ctrl.sv
// Requester side of the register stack: operand fetch to the ALU and result writeback.
// Optional REG_PORT_FORWARD_EN bypasses an in-flight writeback value into a stalled read.
module reg_port_ctrl
  import reg_port_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int NIB_WIDTH      = DEF_NIB_WIDTH,
  parameter int REG_STACK_SIZE = DEF_REG_STACK_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NIB_WIDTH-1:0]  req_src1,
  input  logic [NIB_WIDTH-1:0]  req_src2,
  input  logic [NIB_WIDTH-1:0]  req_dst,
  input  logic                  req_wr,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WORD_WIDTH-1:0] op_a,
  output logic [WORD_WIDTH-1:0] op_b,
  output logic [NIB_WIDTH-1:0]  op_dst,
  output logic                  op_wr,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [NIB_WIDTH-1:0]  wb_num,
  input  logic [WORD_WIDTH-1:0] wb_val,
  output logic [NIB_WIDTH-1:0]  rf_num1,
  output logic [NIB_WIDTH-1:0]  rf_num2,
  input  logic [WORD_WIDTH-1:0] rf_out1,
  input  logic [WORD_WIDTH-1:0] rf_out2,
  output logic                  rf_get_clk,
  output logic [NIB_WIDTH-1:0]  rf_setnum,
  output logic [WORD_WIDTH-1:0] rf_setval,
  output logic                  rf_set_clk
);

  rd_state_t rd_state, rd_next;
  wb_state_t wb_state, wb_next;

  logic                  busy1, busy2;
  logic                  fwd1, fwd2, rd_stall;
  logic                  fwd1_q, fwd2_q;
  logic [WORD_WIDTH-1:0] fwd_val_q;
  logic                  req_accept, wb_accept, op_fire;

  assign req_accept = (rd_state == RD_IDLE) && req_valid;
  assign wb_accept  = (wb_state == WB_IDLE) && wb_valid;
  assign op_fire    = op_valid && op_ready;

  reg_port_ctrl_scoreboard #(
    .NIB_WIDTH      (NIB_WIDTH),
    .REG_STACK_SIZE (REG_STACK_SIZE)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (op_fire && op_wr),
    .set_idx (op_dst),
    .clr_en  (wb_state == WB_STROBE),
    .clr_idx (rf_setnum),
    .rd_idx1 (rf_num1),
    .rd_idx2 (rf_num2),
    .busy1   (busy1),
    .busy2   (busy2)
  );

`ifdef REG_PORT_FORWARD_EN
  logic wb_pending;
  assign wb_pending = (wb_state == WB_SETUP) || (wb_state == WB_STROBE);
  // A busy source whose write is already staged on the set port takes rf_setval.
  assign fwd1 = wb_pending && busy1 && (rf_num1 == rf_setnum);
  assign fwd2 = wb_pending && busy2 && (rf_num2 == rf_setnum);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  assign rd_stall = (busy1 && !fwd1) || (busy2 && !fwd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      wb_state <= WB_IDLE;
    end else begin
      rd_state <= rd_next;
      wb_state <= wb_next;
    end
  end

  always_comb begin
    rd_next   = rd_state;
    req_ready = 1'b0;
    op_valid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) rd_next = RD_ADDR;
      end
      RD_ADDR: if (!rd_stall) rd_next = RD_CAP;
      RD_CAP:  rd_next = RD_HOLD;
      RD_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    wb_next  = wb_state;
    wb_ready = 1'b0;
    case (wb_state)
      WB_IDLE: begin
        wb_ready = 1'b1;
        if (wb_valid) wb_next = WB_SETUP;
      end
      WB_SETUP:  wb_next = WB_STROBE;
      WB_STROBE: wb_next = WB_IDLE;
      default:   wb_next = WB_IDLE;
    endcase
  end

  // Strobes are flopped from next-state so the stack sees clean, glitch-free edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_num1    <= '0;
      rf_num2    <= '0;
      op_dst     <= '0;
      op_wr      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      fwd_val_q  <= '0;
      rf_setnum  <= '0;
      rf_setval  <= '0;
      rf_get_clk <= 1'b0;
      rf_set_clk <= 1'b0;
    end else begin
      rf_get_clk <= (rd_next == RD_CAP);
      rf_set_clk <= (wb_next == WB_STROBE);
      if (req_accept) begin
        rf_num1 <= req_src1;
        rf_num2 <= req_src2;
        op_dst  <= req_dst;
        op_wr   <= req_wr;
      end
      if ((rd_state == RD_ADDR) && !rd_stall) begin
        fwd1_q    <= fwd1;
        fwd2_q    <= fwd2;
        fwd_val_q <= rf_setval;
      end
      if (rd_state == RD_CAP) begin
        op_a <= fwd1_q ? fwd_val_q : rf_out1;
        op_b <= fwd2_q ? fwd_val_q : rf_out2;
      end
      if (wb_accept) begin
        rf_setnum <= wb_num;
        rf_setval <= wb_val;
      end
    end
  end

endmodule
